regfile_operand_read: RTL and testbench

- Operand-read side of the writeback path. Owns the 32-entry architectural register file.
- Returns rs1/rs2 operands to decode/execute, with same-cycle writeback bypass.
- Tracks outstanding multi-cycle loads in a per-register scoreboard. Asserts stall when an operand's producer has not yet written back.
- Sits between instruction decode and execute. Consumes wb_data/rd from the writeback stage.

---
 rtl/rv_core_pkg.sv | 22 ++
 rtl/regfile_operand_read_if.sv | 40 ++++
 rtl/ld_scoreboard.sv | 75 +++++++
 rtl/regfile_operand_read.sv | 66 ++++++
 tb/tb_regfile_operand_read.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_core_pkg.sv
// ============================================================================
//  Module      : rv_core_pkg
//  Description : Shared core constants and types for the operand-read slice.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv_core_pkg;

    localparam int N      = 32;
    localparam int NREG   = 32;
    localparam int AW     = $clog2(NREG);
    localparam int MAX_LD = 4;
    localparam int CW     = $clog2(MAX_LD) + 1;

    typedef logic [N-1:0]  word_t;
    typedef logic [AW-1:0] reg_idx_t;
    typedef logic [CW-1:0] cnt_t;

endpackage

`default_nettype wire

// File: rtl/regfile_operand_read_if.sv
// ============================================================================
//  Module      : regfile_operand_read_if
//  Description : Decode / writeback facing bus of the operand-read block.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface regfile_operand_read_if;
    import rv_core_pkg::*;

    logic     rd_valid;
    reg_idx_t rs1_addr;
    reg_idx_t rs2_addr;
    word_t    rs1_data;
    word_t    rs2_data;
    logic     stall;
    logic     ld_issue;
    reg_idx_t ld_rd;
    logic     ld_ready;
    logic     wb_en;
    reg_idx_t wb_rd;
    word_t    wb_data;
    logic     wb_ld;
    cnt_t     pending_cnt;

    modport master (
        output rd_valid, rs1_addr, rs2_addr, ld_issue, ld_rd,
               wb_en, wb_rd, wb_data, wb_ld,
        input  rs1_data, rs2_data, stall, ld_ready, pending_cnt
    );

    modport slave (
        input  rd_valid, rs1_addr, rs2_addr, ld_issue, ld_rd,
               wb_en, wb_rd, wb_data, wb_ld,
        output rs1_data, rs2_data, stall, ld_ready, pending_cnt
    );

endinterface

`default_nettype wire

// File: rtl/ld_scoreboard.sv
// ============================================================================
//  Module      : ld_scoreboard
//  Description : Per-register busy bits and pending count for in-flight loads.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ld_scoreboard
    import rv_core_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rst_n,
    input  wire logic     i_ld_issue,
    input  wire reg_idx_t i_ld_rd,
    output logic          o_ld_ready,
    input  wire logic     i_wb_en,
    input  wire logic     i_wb_ld,
    input  wire reg_idx_t i_wb_rd,
    input  wire reg_idx_t i_rs1_addr,
    input  wire reg_idx_t i_rs2_addr,
    output logic          o_hit1,
    output logic          o_hit2,
    output cnt_t          o_pending_cnt
);

    logic [NREG-1:1] r_busy;
    logic [NREG-1:1] w_busy_nxt;
    logic [NREG-1:0] w_busy;
    cnt_t            r_cnt;
    logic            w_accept;
    logic            w_clear;
    logic            w_dec;

    // Bit 0 is a constant zero so x0 lookups never report busy.
    assign w_busy     = {r_busy, 1'b0};
    assign o_ld_ready = (r_cnt < CW'(MAX_LD)) & ~w_busy[i_ld_rd];
    assign w_accept   = i_ld_issue & o_ld_ready & (i_ld_rd != '0);
    assign w_clear    = i_wb_en & i_wb_ld & (i_wb_rd != '0);
    assign w_dec      = w_clear & w_busy[i_wb_rd];

    // Set is applied after clear so a new load supersedes a retiring one.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 1; i < NREG; i++) begin
            if (w_clear && (i_wb_rd == reg_idx_t'(i)))
                w_busy_nxt[i] = 1'b0;
            if (w_accept && (i_ld_rd == reg_idx_t'(i)))
                w_busy_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_accept && !w_dec)
                r_cnt <= r_cnt + cnt_t'(1);
            else if (!w_accept && w_dec && (r_cnt != '0))
                r_cnt <= r_cnt - cnt_t'(1);
        end
    end

    function automatic logic f_hit(input reg_idx_t a);
        return (a != '0) & w_busy[a] & ~(w_clear & (i_wb_rd == a));
    endfunction

    assign o_hit1        = f_hit(i_rs1_addr);
    assign o_hit2        = f_hit(i_rs2_addr);
    assign o_pending_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/regfile_operand_read.sv
// ============================================================================
//  Module      : regfile_operand_read
//  Description : Architectural register file with writeback bypass and
//                load-use stall generation.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_operand_read
    import rv_core_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst_n,
    regfile_operand_read_if.slave  bus
);

    word_t r_regs [1:NREG-1];
    logic  w_hit1;
    logic  w_hit2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++)
                r_regs[i] <= '0;
        end else if (bus.wb_en && (bus.wb_rd != '0)) begin
            r_regs[bus.wb_rd] <= bus.wb_data;
        end
    end

    // Same-cycle writeback data takes priority over the stored value.
    function automatic word_t f_read(input reg_idx_t a);
        word_t v;
        v = '0;
        if (a == '0)
            v = '0;
        else if (bus.wb_en && (bus.wb_rd == a))
            v = bus.wb_data;
        else
            v = r_regs[a];
        return v;
    endfunction

    assign bus.rs1_data = f_read(bus.rs1_addr);
    assign bus.rs2_data = f_read(bus.rs2_addr);

    ld_scoreboard u_ld_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ld_issue    (bus.ld_issue),
        .i_ld_rd       (bus.ld_rd),
        .o_ld_ready    (bus.ld_ready),
        .i_wb_en       (bus.wb_en),
        .i_wb_ld       (bus.wb_ld),
        .i_wb_rd       (bus.wb_rd),
        .i_rs1_addr    (bus.rs1_addr),
        .i_rs2_addr    (bus.rs2_addr),
        .o_hit1        (w_hit1),
        .o_hit2        (w_hit2),
        .o_pending_cnt (bus.pending_cnt)
    );

    assign bus.stall = bus.rd_valid & (w_hit1 | w_hit2);

endmodule

`default_nettype wire

// File: tb/tb_regfile_operand_read.sv
// ============================================================================
//  Module      : tb_regfile_operand_read
//  Description : Directed and randomized checks against a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_operand_read;
    import rv_core_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_operand_read_if bus();

    regfile_operand_read dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    word_t m_reg [NREG];
    int    m_q [$];   // outstanding load destinations, oldest first

    function automatic bit m_busy(input int a);
        foreach (m_q[i]) if (m_q[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic word_t m_read(input int a);
        if (a == 0) return '0;
        if (bus.wb_en && int'(bus.wb_rd) == a) return bus.wb_data;
        return m_reg[a];
    endfunction

    function automatic bit m_ready();
        return (m_q.size() < MAX_LD) && !m_busy(int'(bus.ld_rd));
    endfunction

    function automatic bit m_hazard(input int a);
        return (a != 0) && m_busy(a) &&
               !(bus.wb_en && bus.wb_ld && int'(bus.wb_rd) == a);
    endfunction

    function automatic bit m_stall();
        return bus.rd_valid && (m_hazard(int'(bus.rs1_addr)) || m_hazard(int'(bus.rs2_addr)));
    endfunction

    task automatic m_reset();
        m_q.delete();
        foreach (m_reg[i]) m_reg[i] = '0;
    endtask

    task automatic idle();
        bus.rd_valid = 0; bus.rs1_addr = '0; bus.rs2_addr = '0;
        bus.ld_issue = 0; bus.ld_rd = '0;
        bus.wb_en = 0; bus.wb_rd = '0; bus.wb_data = '0; bus.wb_ld = 0;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        bit    acc, clr;
        int    ld, wr;
        word_t wd;
        acc = bus.ld_issue && (bus.ld_rd != '0) && m_ready();
        clr = bus.wb_en && bus.wb_ld && (bus.wb_rd != '0);
        ld  = int'(bus.ld_rd);
        wr  = int'(bus.wb_rd);
        wd  = bus.wb_data;
        if (bus.wb_en && wr != 0) m_reg[wr] = wd;
        if (clr) foreach (m_q[i]) if (m_q[i] == wr) begin m_q.delete(i); break; end
        if (acc) m_q.push_back(ld);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        bus.rd_valid = 1; bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd0;
        #1;
        n_tests++; if (bus.rs1_data !== 32'h0) begin n_fail++; $display("FAIL reset_rs1 got %h want 0", bus.rs1_data); end
        n_tests++; if (bus.rs2_data !== 32'h0) begin n_fail++; $display("FAIL reset_rs2 got %h want 0", bus.rs2_data); end
        n_tests++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready got %b want 1", bus.ld_ready); end
        n_tests++; if (bus.pending_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_pending got %0d want 0", bus.pending_cnt); end
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.stall); end
        tick();
    endtask

    task automatic test_write_bypass();
        idle();
        bus.wb_en = 1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF; bus.rs1_addr = 5'd5;
        #1;
        n_tests++; if (bus.rs1_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_same_cycle got %h want deadbeef", bus.rs1_data); end
        tick();
        bus.wb_en = 0;
        #1;
        n_tests++; if (bus.rs1_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL stored_read got %h want deadbeef", bus.rs1_data); end
        bus.wb_en = 1; bus.wb_rd = 5'd0; bus.wb_data = 32'h1234; bus.rs2_addr = 5'd0;
        #1;
        n_tests++; if (bus.rs2_data !== 32'h0) begin n_fail++; $display("FAIL x0_bypass got %h want 0", bus.rs2_data); end
        tick();
        bus.wb_en = 0;
        #1;
        n_tests++; if (bus.rs2_data !== 32'h0) begin n_fail++; $display("FAIL x0_stored got %h want 0", bus.rs2_data); end
    endtask

    task automatic test_load_hazard();
        idle();
        bus.ld_issue = 1; bus.ld_rd = 5'd7;
        tick();
        bus.ld_issue = 0;
        #1;
        n_tests++; if (bus.pending_cnt !== 3'd1) begin n_fail++; $display("FAIL hazard_pending got %0d want 1", bus.pending_cnt); end
        bus.rd_valid = 1; bus.rs2_addr = 5'd7;
        #1;
        n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL hazard_stall got %b want 1", bus.stall); end
        bus.wb_en = 1; bus.wb_ld = 1; bus.wb_rd = 5'd7; bus.wb_data = 32'h55;
        #1;
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL retire_stall got %b want 0", bus.stall); end
        n_tests++; if (bus.rs2_data !== 32'h55) begin n_fail++; $display("FAIL retire_bypass got %h want 55", bus.rs2_data); end
        tick();
        idle();
        #1;
        n_tests++; if (bus.pending_cnt !== 3'd0) begin n_fail++; $display("FAIL retire_pending got %0d want 0", bus.pending_cnt); end
    endtask

    task automatic retire(input int r);
        idle();
        bus.wb_en = 1; bus.wb_ld = 1; bus.wb_rd = reg_idx_t'(r); bus.wb_data = word_t'($urandom);
        tick();
        idle();
    endtask

    task automatic test_capacity();
        idle();
        for (int i = 1; i <= 4; i++) begin
            bus.ld_issue = 1; bus.ld_rd = reg_idx_t'(i);
            tick();
        end
        bus.ld_rd = 5'd6;
        #1;
        n_tests++; if (bus.pending_cnt !== 3'd4) begin n_fail++; $display("FAIL cap_pending got %0d want 4", bus.pending_cnt); end
        n_tests++; if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL cap_ready got %b want 0", bus.ld_ready); end
        tick();
        bus.ld_issue = 0; bus.rd_valid = 1; bus.rs1_addr = 5'd6;
        #1;
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL cap_refused_busy got stall %b want 0", bus.stall); end
        n_tests++; if (bus.pending_cnt !== 3'd4) begin n_fail++; $display("FAIL cap_refused_cnt got %0d want 4", bus.pending_cnt); end
        // Retire x2 while the x6 request is held until it is accepted.
        bus.rd_valid = 0;
        bus.ld_issue = 1; bus.ld_rd = 5'd6;
        bus.wb_en = 1; bus.wb_ld = 1; bus.wb_rd = 5'd2; bus.wb_data = 32'hA5A5;
        tick();
        bus.wb_en = 0; bus.wb_ld = 0;
        #1;
        n_tests++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL cap_ready_after_retire got %b want 1", bus.ld_ready); end
        tick();
        bus.ld_issue = 0; bus.rd_valid = 1; bus.rs1_addr = 5'd6;
        #1;
        n_tests++; if (bus.pending_cnt !== 3'd4) begin n_fail++; $display("FAIL cap_swap_cnt got %0d want 4", bus.pending_cnt); end
        n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL cap_x6_busy got stall %b want 1", bus.stall); end
        retire(1); retire(3); retire(4); retire(6);
        #1;
        n_tests++; if (bus.pending_cnt !== 3'd0) begin n_fail++; $display("FAIL cap_drain got %0d want 0", bus.pending_cnt); end
    endtask

    task automatic test_waw();
        idle();
        bus.ld_issue = 1; bus.ld_rd = 5'd9;
        tick();
        #1;
        n_tests++; if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL waw_ready got %b want 0", bus.ld_ready); end
        tick();
        bus.ld_issue = 0;
        #1;
        n_tests++; if (bus.pending_cnt !== 3'd1) begin n_fail++; $display("FAIL waw_refused_cnt got %0d want 1", bus.pending_cnt); end
        bus.ld_issue = 1;
        bus.wb_en = 1; bus.wb_ld = 1; bus.wb_rd = 5'd9; bus.wb_data = 32'h99;
        tick();
        bus.wb_en = 0; bus.wb_ld = 0;
        tick();
        bus.ld_issue = 0; bus.rd_valid = 1; bus.rs1_addr = 5'd9;
        #1;
        n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL waw_reissue_busy got stall %b want 1", bus.stall); end
        n_tests++; if (bus.pending_cnt !== 3'd1) begin n_fail++; $display("FAIL waw_reissue_cnt got %0d want 1", bus.pending_cnt); end
        // Load issue and stray retire to the same idle register: set wins.
        bus.rd_valid = 0;
        bus.ld_issue = 1; bus.ld_rd = 5'd10;
        bus.wb_en = 1; bus.wb_ld = 1; bus.wb_rd = 5'd10; bus.wb_data = 32'h1010;
        tick();
        idle();
        bus.rd_valid = 1; bus.rs1_addr = 5'd10;
        #1;
        n_tests++; if (bus.pending_cnt !== 3'd2) begin n_fail++; $display("FAIL setwins_cnt got %0d want 2", bus.pending_cnt); end
        n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL setwins_busy got stall %b want 1", bus.stall); end
        n_tests++; if (bus.rs1_data !== 32'h1010) begin n_fail++; $display("FAIL setwins_data got %h want 1010", bus.rs1_data); end
        retire(11);
        #1;
        n_tests++; if (bus.pending_cnt !== 3'd2) begin n_fail++; $display("FAIL idle_retire_cnt got %0d want 2", bus.pending_cnt); end
        retire(9); retire(10);
        #1;
        n_tests++; if (bus.pending_cnt !== 3'd0) begin n_fail++; $display("FAIL waw_drain got %0d want 0", bus.pending_cnt); end
    endtask

    task automatic test_async_reset();
        idle();
        bus.wb_en = 1; bus.wb_rd = 5'd12; bus.wb_data = 32'hCAFE;
        tick();
        idle();
        for (int i = 12; i <= 14; i++) begin
            bus.ld_issue = 1; bus.ld_rd = reg_idx_t'(i);
            tick();
        end
        idle();
        bus.rd_valid = 1; bus.rs1_addr = 5'd12; bus.rs2_addr = 5'd13;
        #1;
        n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL prereset_stall got %b want 1", bus.stall); end
        n_tests++; if (bus.pending_cnt !== 3'd3) begin n_fail++; $display("FAIL prereset_cnt got %0d want 3", bus.pending_cnt); end
        @(negedge clk);
        #1 rst_n = 0;
        m_reset();
        #1;
        n_tests++; if (bus.pending_cnt !== 3'd0) begin n_fail++; $display("FAIL areset_cnt got %0d want 0", bus.pending_cnt); end
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL areset_stall got %b want 0", bus.stall); end
        n_tests++; if (bus.rs1_data !== 32'h0) begin n_fail++; $display("FAIL areset_reg got %h want 0", bus.rs1_data); end
        #1 rst_n = 1;
        @(posedge clk); #1;
        retire(13);
        bus.rs2_addr = 5'd13;
        #1;
        n_tests++; if (bus.pending_cnt !== 3'd0) begin n_fail++; $display("FAIL stale_retire_cnt got %0d want 0", bus.pending_cnt); end
        n_tests++; if (bus.rs2_data !== m_reg[13]) begin n_fail++; $display("FAIL stale_retire_data got %h want %h", bus.rs2_data, m_reg[13]); end
    endtask

    task automatic test_random();
        word_t e_rs1, e_rs2;
        for (int c = 0; c < 400; c++) begin
            bus.rd_valid = 1'($urandom);
            bus.rs1_addr = ($urandom_range(0, 1) != 0) ? reg_idx_t'($urandom_range(0, 7)) : reg_idx_t'($urandom);
            bus.rs2_addr = ($urandom_range(0, 1) != 0) ? reg_idx_t'($urandom_range(0, 7)) : reg_idx_t'($urandom);
            bus.ld_issue = ($urandom_range(0, 2) == 0);
            bus.ld_rd    = reg_idx_t'($urandom_range(0, 7));
            bus.wb_en    = 1'($urandom);
            bus.wb_ld    = 1'($urandom);
            bus.wb_data  = word_t'($urandom);
            if (m_q.size() > 0 && $urandom_range(0, 1) != 0)
                bus.wb_rd = reg_idx_t'(m_q[$urandom_range(0, m_q.size() - 1)]);
            else
                bus.wb_rd = reg_idx_t'($urandom_range(0, 7));
            #1;
            e_rs1 = m_read(int'(bus.rs1_addr));
            e_rs2 = m_read(int'(bus.rs2_addr));
            n_tests++; if (bus.rs1_data !== e_rs1) begin n_fail++; $display("FAIL rnd_rs1 cyc %0d got %h want %h", c, bus.rs1_data, e_rs1); end
            n_tests++; if (bus.rs2_data !== e_rs2) begin n_fail++; $display("FAIL rnd_rs2 cyc %0d got %h want %h", c, bus.rs2_data, e_rs2); end
            n_tests++; if (bus.stall !== m_stall()) begin n_fail++; $display("FAIL rnd_stall cyc %0d got %b want %b", c, bus.stall, m_stall()); end
            n_tests++; if (bus.ld_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ld_ready cyc %0d got %b want %b", c, bus.ld_ready, m_ready()); end
            n_tests++; if (int'(bus.pending_cnt) != m_q.size()) begin n_fail++; $display("FAIL rnd_pending cyc %0d got %0d want %0d", c, bus.pending_cnt, m_q.size()); end
            tick();
        end
        idle();
    endtask

    initial begin
        rst_n = 0;
        idle();
        test_reset();
        test_write_bypass();
        test_load_hazard();
        test_capacity();
        test_waw();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
